// File: rtl/wrr_arb_tree.sv
// Weighted round-robin N:1 arbiter with packet locking; combinational outputs (zero latency).
// A stalled decision is held until gnt_i when LockIn is set; an owner mid-packet keeps the output.
module wrr_arb_tree #(
  parameter int unsigned NumIn       = 8,
  parameter int unsigned DataWidth   = 32,
  parameter type         DataType    = logic [DataWidth-1:0],
  parameter int unsigned WeightWidth = 4,
  parameter bit          AxiVldRdy   = 1'b0,
  parameter bit          LockIn      = 1'b1,
  parameter int unsigned IdxWidth    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [NumIn-1:0][WeightWidth-1:0]   weight_i,
  input  logic [NumIn-1:0]                    req_i,
  input  logic [NumIn-1:0]                    last_i,
  input  DataType                             data_i [NumIn],
  output logic [NumIn-1:0]                    gnt_o,
  output logic                                req_o,
  output logic                                last_o,
  output DataType                             data_o,
  output logic [IdxWidth-1:0]                 idx_o,
  input  logic                                gnt_i
);

  if (NumIn == 1) begin : gen_pass
    assign req_o    = req_i[0];
    assign gnt_o[0] = gnt_i;
    assign idx_o    = '0;
    assign last_o   = last_i[0];
    assign data_o   = data_i[0];
  end else begin : gen_arb
    localparam logic [IdxWidth:0]   NumInW  = (IdxWidth+1)'(NumIn);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumIn - 1);

    logic [IdxWidth-1:0]    rr_q, rr_d, hold_idx_q, hold_idx_d;
    logic [IdxWidth-1:0]    sel, search_idx;
    logic [WeightWidth-1:0] cnt_q, cnt_d, n, we;
    logic                   lock_q, lock_d, hold_q, hold_d;
    logic                   any_req, found;
    logic [IdxWidth:0]      cand;

    assign any_req = |req_i;

    // Circular search for the first requester starting at the current owner.
    always_comb begin
      search_idx = '0;
      found      = 1'b0;
      cand       = '0;
      for (int unsigned k = 0; k < NumIn; k++) begin
        cand = {1'b0, rr_q} + (IdxWidth+1)'(k);
        if (cand >= NumInW) cand = cand - NumInW;
        if (!found && req_i[cand[IdxWidth-1:0]]) begin
          found      = 1'b1;
          search_idx = cand[IdxWidth-1:0];
        end
      end
    end

    always_comb begin
      sel = search_idx;
      if (!any_req)              sel = '0;
      else if (lock_q)           sel = rr_q;
      else if (LockIn && hold_q) sel = hold_idx_q;
    end

    assign req_o  = (lock_q | hold_q) ? req_i[sel] : any_req;
    assign last_o = any_req & last_i[sel];
    assign data_o = data_i[sel];
    assign idx_o  = sel;

    always_comb begin
      gnt_o = '0;
      for (int unsigned i = 0; i < NumIn; i++) begin
        gnt_o[i] = gnt_i & (sel == IdxWidth'(i)) & (AxiVldRdy | req_i[i]);
      end
    end

    // cnt_q stays below the effective weight, so n cannot wrap.
    always_comb begin
      rr_d       = rr_q;
      cnt_d      = cnt_q;
      lock_d     = lock_q;
      hold_d     = req_o & ~gnt_i & ~lock_q;
      hold_idx_d = sel;
      n          = ((sel == rr_q) ? cnt_q : '0) + WeightWidth'(1);
      we         = (weight_i[sel] == '0) ? WeightWidth'(1) : weight_i[sel];
      if (req_o && gnt_i) begin
        if (!last_o) begin
          lock_d = 1'b1;
          rr_d   = sel;
          if (sel != rr_q) cnt_d = '0;
        end else begin
          lock_d = 1'b0;
          if (n >= we) begin
            rr_d  = (sel == LastIdx) ? '0 : sel + IdxWidth'(1);
            cnt_d = '0;
          end else begin
            rr_d  = sel;
            cnt_d = n;
          end
        end
      end
      if (flush_i) begin
        rr_d       = '0;
        cnt_d      = '0;
        lock_d     = 1'b0;
        hold_d     = 1'b0;
        hold_idx_d = '0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rr_q       <= '0;
        cnt_q      <= '0;
        lock_q     <= 1'b0;
        hold_q     <= 1'b0;
        hold_idx_q <= '0;
      end else begin
        rr_q       <= rr_d;
        cnt_q      <= cnt_d;
        lock_q     <= lock_d;
        hold_q     <= hold_d;
        hold_idx_q <= hold_idx_d;
      end
    end
  end

endmodule

// File: tb/tb_wrr_arb_tree.sv
// Bench for wrr_arb_tree: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the weighted round-robin rules.
module tb_wrr_arb_tree;
  localparam int N = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic [N-1:0][3:0] weight_i = '0;
  logic [N-1:0]      req_i = '0;
  logic [N-1:0]      last_i = '0;
  logic [15:0]       data_i [N];
  logic [N-1:0]      gnt_o;
  logic              req_o;
  logic              last_o;
  logic [15:0]       data_o;
  logic [1:0]        idx_o;
  logic              gnt_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: owner index, packets served this turn, mid-packet flag, stall hold.
  int m_rr = 0, m_cnt = 0, m_hidx = 0;
  bit m_lock = 1'b0, m_hold = 1'b0;

  int exp_seq[10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};

  wrr_arb_tree #(
    .NumIn(N), .DataWidth(16), .WeightWidth(4), .AxiVldRdy(1'b0), .LockIn(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .weight_i(weight_i),
    .req_i(req_i), .last_i(last_i), .data_i(data_i), .gnt_o(gnt_o), .req_o(req_o),
    .last_o(last_o), .data_o(data_o), .idx_o(idx_o), .gnt_i(gnt_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_sel();
    if (req_i == '0) return 0;
    if (m_lock) return m_rr;
    if (m_hold) return m_hidx;
    for (int k = 0; k < N; k++) if (req_i[(m_rr + k) % N]) return (m_rr + k) % N;
    return 0;
  endfunction

  function automatic bit m_req();
    if (req_i == '0) return 1'b0;
    return (m_lock || m_hold) ? req_i[m_sel()] : 1'b1;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    int s, done, quota;
    bit r;
    if (!rst_ni || flush_i) begin
      m_rr <= 0; m_cnt <= 0; m_lock <= 1'b0; m_hold <= 1'b0; m_hidx <= 0;
    end else begin
      s = m_sel();
      r = m_req();
      m_hold <= r && !gnt_i && !m_lock;
      m_hidx <= s;
      if (r && gnt_i) begin
        if (!last_i[s]) begin
          m_lock <= 1'b1;
          m_rr   <= s;
          if (s != m_rr) m_cnt <= 0;
        end else begin
          done  = ((s == m_rr) ? m_cnt : 0) + 1;
          quota = (weight_i[s] == 0) ? 1 : int'(weight_i[s]);
          m_lock <= 1'b0;
          if (done >= quota) begin
            m_rr <= (s + 1) % N; m_cnt <= 0;
          end else begin
            m_rr <= s; m_cnt <= done;
          end
        end
      end
    end
  end

  always @(negedge clk_i) begin
    int s;
    logic [N-1:0] eg;
    if (chk_en && rst_ni) begin
      s  = m_sel();
      eg = '0;
      if (gnt_i && req_i[s]) eg[s] = 1'b1;
      chk("req_o", req_o, m_req());
      chk("idx_o", idx_o, s);
      chk("last_o", last_o, (req_i != '0) && last_i[s]);
      chk("gnt_o", gnt_o, eg);
      chk("data_o", data_o, data_i[s]);
      chk("rr_q", dut.gen_arb.rr_q, m_rr);
      chk("cnt_q", dut.gen_arb.cnt_q, m_cnt);
      chk("lock_q", dut.gen_arb.lock_q, m_lock);
      if (m_lock) assert (req_i[m_rr]) else $error("owner dropped req mid-packet");
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] rq, input logic [N-1:0] lt, input logic g);
    req_i = rq; last_i = lt; gnt_i = g; flush_i = 1'b0;
  endtask

  task automatic do_flush();
    drive('0, '0, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) data_i[i] = 16'(16'hA5A5 + i);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_req_o", req_o, 0);
    chk("rst_idx_o", idx_o, 0);
    chk("rst_gnt_o", gnt_o, 0);
    chk("rst_last_o", last_o, 0);
    chk("rst_data_o", data_o, 16'hA5A5);
    chk("rst_rr_q", dut.gen_arb.rr_q, 0);
    tick();

    // Weights {3,1,2,1}, everyone requesting single beats.
    weight_i = {4'd1, 4'd2, 4'd1, 4'd3};
    do_flush();
    for (int i = 0; i < 10; i++) begin
      drive(4'hF, 4'hF, 1'b1); #1;
      chk("seq_wrr_idx", idx_o, exp_seq[i]);
      tick();
    end

    // Weight 0 acts as 1.
    weight_i = {4'd1, 4'd1, 4'd0, 4'd1};
    do_flush();
    for (int i = 0; i < 6; i++) begin
      drive(4'b0011, 4'b0011, 1'b1); #1;
      chk("w0_alt_idx", idx_o, i % 2);
      tick();
    end

    // Four-beat packet on input 0 with input 1 waiting.
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    do_flush();
    for (int i = 0; i < 4; i++) begin
      drive(4'b0011, (i == 3) ? 4'b0011 : 4'b0010, 1'b1); #1;
      chk("pkt_idx", idx_o, 0);
      chk("pkt_gnt1", gnt_o[1], 0);
      tick();
      chk("pkt_rr", dut.gen_arb.rr_q, (i == 3) ? 1 : 0);
    end
    drive(4'b0010, 4'b0010, 1'b1); #1;
    chk("pkt_next_idx", idx_o, 1);
    tick();

    // Owner 1, only input 3 requesting with weight 2.
    weight_i = {4'd2, 4'd1, 4'd1, 4'd1};
    do_flush();
    drive(4'b0001, 4'b0001, 1'b1); tick();
    chk("w2_rr_start", dut.gen_arb.rr_q, 1);
    drive(4'b1000, 4'b1000, 1'b1); #1;
    chk("w2_idx_a", idx_o, 3);
    tick();
    chk("w2_rr_a", dut.gen_arb.rr_q, 3);
    chk("w2_cnt_a", dut.gen_arb.cnt_q, 1);
    drive(4'b1000, 4'b1000, 1'b1); #1;
    chk("w2_idx_b", idx_o, 3);
    tick();
    chk("w2_rr_b", dut.gen_arb.rr_q, 0);
    chk("w2_cnt_b", dut.gen_arb.cnt_q, 0);

    // Stalled decision is held while a lower index starts requesting.
    do_flush();
    drive(4'b0100, 4'b0100, 1'b0); #1; chk("hold_idx_c1", idx_o, 2); tick();
    drive(4'b0101, 4'b0101, 1'b0); #1; chk("hold_idx_c2", idx_o, 2); tick();
    drive(4'b0101, 4'b0101, 1'b0); #1; chk("hold_idx_c3", idx_o, 2); tick();
    drive(4'b0101, 4'b0101, 1'b1); #1;
    chk("hold_idx_c4", idx_o, 2);
    chk("hold_gnt_c4", gnt_o, 4'b0100);
    tick();

    // Flush beats a same-cycle handshake mid-packet.
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    do_flush();
    drive(4'b0010, 4'b0000, 1'b1); tick();
    chk("lock_set", dut.gen_arb.lock_q, 1);
    chk("lock_rr", dut.gen_arb.rr_q, 1);
    drive(4'b0010, 4'b0000, 1'b1); flush_i = 1'b1; tick(); flush_i = 1'b0;
    chk("flush_rr", dut.gen_arb.rr_q, 0);
    chk("flush_lock", dut.gen_arb.lock_q, 0);
    chk("flush_cnt", dut.gen_arb.cnt_q, 0);

    // Asynchronous reset pulse mid-cycle with nonzero count and lock.
    weight_i = {4'd1, 4'd1, 4'd3, 4'd1};
    drive(4'b0010, 4'b0010, 1'b1); tick();
    drive(4'b0010, 4'b0000, 1'b1); tick();
    chk("pre_rst_cnt", dut.gen_arb.cnt_q, 1);
    chk("pre_rst_lock", dut.gen_arb.lock_q, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_rr", dut.gen_arb.rr_q, 0);
    chk("arst_cnt", dut.gen_arb.cnt_q, 0);
    chk("arst_lock", dut.gen_arb.lock_q, 0);
    rst_ni = 1'b1;
    tick();

    // Random traffic; the owner keeps requesting until its last beat.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_i[i]  = ($urandom_range(0, 2) != 0);
        last_i[i] = ($urandom_range(0, 1) != 0);
        data_i[i] = 16'($urandom);
        if ($urandom_range(0, 15) == 0) weight_i[i] = 4'($urandom_range(0, 4));
      end
      if (m_lock) req_i[m_rr] = 1'b1;
      gnt_i   = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 63) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wrr_arb_tree.md
Name: wrr_arb_tree

Overview:
- Weighted round-robin N:1 arbiter with packet locking; successor to the plain round-robin arbitration tree.
- Each input gets up to weight_i[i] consecutive packets per turn. A packet is a run of beats ending with last_i; it is never interleaved with another input's beats.
- Sits in front of shared FPU/interconnect resources where inputs need unequal bandwidth shares and multi-beat transfers must stay atomic.

Parameters:
- NumIn, 8, number of inputs (>=1).
- DataWidth, 32, payload width; unused if DataType is overridden.
- DataType, logic [DataWidth-1:0], payload type.
- WeightWidth, 4, width of each weight field.
- AxiVldRdy, 1'b0, when 1, gnt_o does not depend on req_i.
- LockIn, 1'b1, when 1, a stalled decision (req_o & ~gnt_i) is held.
- IdxWidth, (NumIn>1)?$clog2(NumIn):1, derived; do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- flush_i  in  1  synchronous clear of all arbiter state.
- weight_i  in  NumIn x WeightWidth  packets per turn per input; 0 is treated as 1.
- req_i  in  NumIn  input valid.
- last_i  in  NumIn  final beat of the packet on input i.
- data_i  in  NumIn x DataType  input payloads.
- gnt_o  out  NumIn  input granted (one-hot or zero).
- req_o  out  1  output valid.
- last_o  out  1  last_i of the selected input.
- data_o  out  DataType  selected payload.
- idx_o  out  IdxWidth  selected input index.
- gnt_i  in  1  output ready.

Behaviour:
- Reset is rst_ni, asynchronous, active-low, on clock clk_i.
- State registers:
  - rr_q: index of the highest-priority input (owner).
  - cnt_q: packets the owner has completed in its current turn (WeightWidth bits).
  - lock_q: set while the owner is mid-packet.
  - hold_q, hold_idx_q: stall hold.
- Reset and flush_i clear all state to 0. Flush takes priority over handshakes in the same cycle.
- All outputs are combinational; latency 0.
- With req_i=0: req_o=0, idx_o=0, gnt_o=0, last_o=0, and data_o equals data_i[0].
- Selection, in priority order:
  - lock_q=1: sel = rr_q.
  - LockIn=1 and hold_q=1: sel = hold_idx_q.
  - Otherwise: sel = first index with req_i set, searching circularly from rr_q upward.
- req_o = req_i[sel] if lock_q or hold_q is set, else |req_i.
- idx_o = sel; data_o = data_i[sel]; last_o = last_i[sel].
- gnt_o[i] = gnt_i & (i==sel) & (AxiVldRdy | req_i[i]).
- hold_q is set to (req_o & ~gnt_i & ~lock_q), and hold_idx_q is loaded with sel.
- Handshake (req_o & gnt_i), with winner w=sel:
  - last_o=0: lock_q<=1 and rr_q<=w. If w!=rr_q, cnt_q<=0.
  - last_o=1: lock_q<=0. Compute n = (w==rr_q ? cnt_q : 0) + 1 and we = max(weight_i[w],1).
    - If n>=we: rr_q <= (w==NumIn-1) ? 0 : w+1, and cnt_q<=0.
    - Else: rr_q<=w, cnt_q<=n.
- Arithmetic: cnt_q is always < we, so n <= 2^WeightWidth-1 and no overflow occurs. Compare against weight_i as sampled in the handshake cycle; weights may change at any time.
- Mid-packet: the owner must hold req_i high until its last beat (checked by an assertion in the bench). Other inputs are never granted.
- Single-beat packets (last_i=1 on the first beat) never set lock_q.
- NumIn==1: pass-through. req_o=req_i[0], gnt_o[0]=gnt_i, idx_o=0, no state.

Test Plan:
- NumIn=4, weights {3,1,2,1}, all req=1, last=1, gnt_i=1 -> idx_o sequence 0,0,0,1,2,2,3,0,0,0,...
- Weights {1,0,1,1}, only inputs 0 and 1 requesting, single beats -> idx_o alternates 0,1,0,1; weight 0 behaves as 1.
- Weights all 1; input 0 sends a 4-beat packet (last on beat 4) while input 1 is requesting -> idx_o=0 for 4 beats, then 1. gnt_o[1] stays 0 throughout, and rr_q does not advance until beat 4.
- rr_q=1 with only input 3 requesting, weight 2 -> grant 3, then rr_q=3, cnt_q=1. A second packet from 3 -> rr_q=0.
- LockIn=1: only input 2 requests, gnt_i=0 for 3 cycles, input 0 rises in cycle 2 -> idx_o stays 2. With gnt_i=1 in cycle 4, input 2 is granted.
- Mid-packet on input 1 (lock_q=1), assert flush_i -> next cycle rr_q=0, lock_q=0, cnt_q=0. Repeat with an async rst_ni pulse mid-cycle -> state clears immediately.
